serial_config_loader: RTL and testbench
=======================================

# serial_config_loader

Parametrised serial configuration streamer for the FPGA test harness. It selects a configuration word from a preset table or from an external handshake, then shifts it into the design under test over a 3-wire serial bus (`sen`, `sclk`, `sdata`). Width, preset count, SCLK rate and bit order are generic, and it adds repeat and external-load modes. It sits between the debounced board buttons and the DUT `ui_in` configuration pins.

## Interface

Parameters:
- `CFG_WIDTH`, 52: configuration word width in bits (≥2).
- `NUM_PRESETS`, 8: number of preset words (≥1).
- `SCLK_DIV`, 1: clk cycles per SCLK phase, high and low (≥1).
- `LSB_FIRST`, 1: 1 = bit 0 shifted first; 0 = bit `CFG_WIDTH-1` first.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `preset_table` in `NUM_PRESETS*CFG_WIDTH`: preset i occupies bits `[i*CFG_WIDTH +: CFG_WIDTH]`; static.
- `next_req` in 1: level (debounced); rising edge sends current preset, then advances.
- `repeat_req` in 1: level; rising edge resends the last-sent preset.
- `ext_valid` in 1: external word offered.
- `ext_cfg` in `CFG_WIDTH`: external word.
- `ext_ready` out 1: high only in IDLE; transfer when `ext_valid & ext_ready`.
- `sen` out 1: serial enable.
- `sclk` out 1: serial clock; DUT samples on rising edge.
- `sdata` out 1: serial data.
- `busy` out 1: high from ARM through END.
- `done` out 1: one-cycle pulse at end of transfer.
- `cur_idx` out `$clog2(NUM_PRESETS)` (min 1): preset the next `next_req` sends.

## Operation

- Edge detect: `req_q <= req` every cycle, including during reset. Edge = `req & ~req_q`. Edges arriving outside IDLE are dropped, not queued.
- Source priority in IDLE, same cycle: ext handshake > next edge > repeat edge.
- State sequence: IDLE → ARM → EN → HIGH → LOW → (HIGH… | END) → IDLE.
- **IDLE**: `sen=0`, `sclk=0`. On an accepted source, load the shift register and the source tag, then go to ARM.
  - next: `preset[cur_idx]`.
  - repeat: `preset[last_idx]`.
  - ext: `ext_cfg`.
- **ARM**: one cycle; `sen=0`, `sclk=0`; `busy=1`; `sdata` presents the first bit. Bit counter cleared.
- **EN**: one cycle; `sen=1`.
- **HIGH**: `sclk=1` for `SCLK_DIV` cycles.
- **LOW**: `sclk=0` for `SCLK_DIV` cycles. On its last cycle:
  - shift the register toward the output end;
  - if bit counter = `CFG_WIDTH-1`, go to END; otherwise increment the counter and go to HIGH.
- **END**: one cycle; `sen=0`, `done=1`.
  - Source next: `last_idx <= cur_idx`; `cur_idx <= (cur_idx == NUM_PRESETS-1) ? 0 : cur_idx+1`.
  - Source repeat or ext: indices unchanged.
- `sdata` = shift register LSB when `LSB_FIRST=1`, MSB when `LSB_FIRST=0`. It is stable for the whole HIGH phase.
- `NUM_PRESETS=1`: `cur_idx` stays 0.
- Repeat before any next: sends preset 0 (`last_idx` resets to 0).

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- Reset values:
  - outputs: `sen=0`, `sclk=0`, `sdata=0`, `busy=0`, `done=0`, `ext_ready=0` (in reset cycle), `cur_idx=0`;
  - internal: `last_idx=0`, shift register 0, state IDLE.
- Reset mid-transfer: the bus returns to idle on the next edge. No `done` pulse is issued and no index update occurs.
- Latency: a request sampled in IDLE at cycle 0 gives ARM at cycle 1, `sen` rising at cycle 2, and the first `sclk` rise at cycle 3.
- Transfer length: `busy` is high for `3 + 2*SCLK_DIV*CFG_WIDTH` cycles. `done` is asserted in the last of these cycles.
- Back-to-back: a new request can be accepted in the cycle after END, since IDLE lasts at least one cycle.
- `ext_ready` falls in the cycle after acceptance.

## Structure

- Package `serial_config_pkg`: state enum (IDLE, ARM, EN, HIGH, LOW, END), source-tag enum (NEXT, REPEAT, EXT), and a wrap-increment function.
- Sub-module `rise_detect`, instanced twice, one each for `next_req` and `repeat_req`.
- Phase counter width is `$clog2(SCLK_DIV)` (min 1). Bit counter width is `$clog2(CFG_WIDTH)`.

## Test plan

Common configuration: `CFG_WIDTH=8`, `NUM_PRESETS=3`, `SCLK_DIV=1`, `LSB_FIRST=1`, presets `{0xA5, 0x3C, 0xF0}`.

1. Single next pulse → DUT-side capture on `sclk` rising = 0xA5; `busy` high 19 cycles; `done` single pulse; `cur_idx` 0→1.
2. Four next pulses → words sent 0xA5, 0x3C, 0xF0, 0xA5; `cur_idx` sequence 1, 2, 0, 1.
3. Next, then repeat → 0xA5 sent twice; `cur_idx` remains 1. With `LSB_FIRST=0` and `SCLK_DIV=3` → 0xA5 captured; `busy` 51 cycles; each `sclk` phase 3 cycles.
4. `ext_valid` with `ext_cfg=0x5A` in the same cycle as a next edge → 0x5A sent; `cur_idx` unchanged. A next edge during the transfer is dropped.
5. Reset asserted while `busy` is high, at bit 4 → next cycle `sen=0`, `sclk=0`, `busy=0`, `cur_idx=0`; no `done` pulse.
6. `next_req` held high for 100 cycles → exactly one transfer.

Source files
------------

// File: rtl/serial_config_pkg.sv
// Shared types and helpers for the serial configuration loader.
package serial_config_pkg;

  typedef enum logic [2:0] {IDLE, ARM, EN, HIGH, LOW, END} state_t;
  typedef enum logic [1:0] {NEXT, REPEAT, EXT} src_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-debounced level request.
module rise_detect (
  input  logic clk,
  input  logic req,
  output logic rise
);

  logic req_q;

  // Sampled unconditionally, so a level held through reset does not fire on release.
  always_ff @(posedge clk) begin
    req_q <= req;
  end

  assign rise = req & ~req_q;

endmodule

// File: rtl/serial_config_loader.sv
// Selects a preset, repeated or external configuration word and shifts it out over sen/sclk/sdata.
module serial_config_loader
  import serial_config_pkg::*;
#(
  parameter int unsigned CFG_WIDTH   = 52,
  parameter int unsigned NUM_PRESETS = 8,
  parameter int unsigned SCLK_DIV    = 1,
  parameter int unsigned LSB_FIRST   = 1,
  localparam int unsigned IDX_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1,
  localparam int unsigned PH_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1,
  localparam int unsigned BIT_W = $clog2(CFG_WIDTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PRESETS*CFG_WIDTH-1:0] preset_table,
  input  logic                             next_req,
  input  logic                             repeat_req,
  input  logic                             ext_valid,
  input  logic [CFG_WIDTH-1:0]             ext_cfg,
  output logic                             ext_ready,
  output logic                             sen,
  output logic                             sclk,
  output logic                             sdata,
  output logic                             busy,
  output logic                             done,
  output logic [IDX_W-1:0]                 cur_idx
);

  logic next_rise, repeat_rise;

  rise_detect u_next_rise   (.clk(clk), .req(next_req),   .rise(next_rise));
  rise_detect u_repeat_rise (.clk(clk), .req(repeat_req), .rise(repeat_rise));

  state_t               state, state_nx;
  src_t                 src, src_nx;
  logic [CFG_WIDTH-1:0] sr, sr_nx;
  logic [PH_W-1:0]      ph, ph_nx;
  logic [BIT_W-1:0]     bcnt, bcnt_nx;
  logic [IDX_W-1:0]     last_idx, last_nx, cur_nx;
  logic [CFG_WIDTH-1:0] preset_cur, preset_last;
  logic                 ph_last;

  assign preset_cur  = preset_table[int'(cur_idx)  * CFG_WIDTH +: CFG_WIDTH];
  assign preset_last = preset_table[int'(last_idx) * CFG_WIDTH +: CFG_WIDTH];
  assign ph_last     = (ph == PH_W'(SCLK_DIV - 1));

  always_comb begin
    state_nx = state;
    src_nx   = src;
    sr_nx    = sr;
    ph_nx    = ph;
    bcnt_nx  = bcnt;
    cur_nx   = cur_idx;
    last_nx  = last_idx;
    unique case (state)
      IDLE: begin
        if (ext_valid && ext_ready) begin
          sr_nx    = ext_cfg;
          src_nx   = EXT;
          state_nx = ARM;
        end else if (next_rise) begin
          sr_nx    = preset_cur;
          src_nx   = NEXT;
          state_nx = ARM;
        end else if (repeat_rise) begin
          sr_nx    = preset_last;
          src_nx   = REPEAT;
          state_nx = ARM;
        end
      end
      ARM: begin
        bcnt_nx  = '0;
        ph_nx    = '0;
        state_nx = EN;
      end
      EN: begin
        ph_nx    = '0;
        state_nx = HIGH;
      end
      HIGH: begin
        if (ph_last) begin
          ph_nx    = '0;
          state_nx = LOW;
        end else begin
          ph_nx = ph + 1'b1;
        end
      end
      LOW: begin
        if (ph_last) begin
          ph_nx = '0;
          if (LSB_FIRST != 0) sr_nx = {1'b0, sr[CFG_WIDTH-1:1]};
          else                sr_nx = {sr[CFG_WIDTH-2:0], 1'b0};
          if (bcnt == BIT_W'(CFG_WIDTH - 1)) begin
            state_nx = END;
          end else begin
            bcnt_nx  = bcnt + 1'b1;
            state_nx = HIGH;
          end
        end else begin
          ph_nx = ph + 1'b1;
        end
      end
      END: begin
        if (src == NEXT) begin
          last_nx = cur_idx;
          cur_nx  = IDX_W'(wrap_inc(32'(cur_idx), NUM_PRESETS));
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= NEXT;
      sr        <= '0;
      ph        <= '0;
      bcnt      <= '0;
      cur_idx   <= '0;
      last_idx  <= '0;
      ext_ready <= 1'b0;
      sen       <= 1'b0;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      src       <= src_nx;
      sr        <= sr_nx;
      ph        <= ph_nx;
      bcnt      <= bcnt_nx;
      cur_idx   <= cur_nx;
      last_idx  <= last_nx;
      ext_ready <= (state_nx == IDLE);
      sen       <= (state_nx == EN) || (state_nx == HIGH) || (state_nx == LOW);
      sclk      <= (state_nx == HIGH);
      sdata     <= (LSB_FIRST != 0) ? sr_nx[0] : sr_nx[CFG_WIDTH-1];
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == END);
    end
  end

endmodule

// File: tb/tb_serial_config_loader.sv
// Directed bench for serial_config_loader: LSB-first/div-1 and MSB-first/div-3 instances.
module tb_serial_config_loader;

  localparam logic [23:0] PRESETS = {8'hF0, 8'h3C, 8'hA5};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       next_req = 1'b0, repeat_req = 1'b0, ext_valid = 1'b0;
  logic [7:0] ext_cfg = 8'h00;
  logic       ext_ready, sen, sclk, sdata, busy, done;
  logic [1:0] cur_idx;

  logic       next_req2 = 1'b0, repeat_req2 = 1'b0, ext_valid2 = 1'b0;
  logic [7:0] ext_cfg2 = 8'h00;
  logic       ext_ready2, sen2, sclk2, sdata2, busy2, done2;
  logic [1:0] cur_idx2;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_config_loader #(.CFG_WIDTH(8), .NUM_PRESETS(3), .SCLK_DIV(1), .LSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .preset_table(PRESETS),
    .next_req(next_req), .repeat_req(repeat_req), .ext_valid(ext_valid), .ext_cfg(ext_cfg),
    .ext_ready(ext_ready), .sen(sen), .sclk(sclk), .sdata(sdata),
    .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  serial_config_loader #(.CFG_WIDTH(8), .NUM_PRESETS(3), .SCLK_DIV(3), .LSB_FIRST(0)) dut2 (
    .clk(clk), .reset(reset), .preset_table(PRESETS),
    .next_req(next_req2), .repeat_req(repeat_req2), .ext_valid(ext_valid2), .ext_cfg(ext_cfg2),
    .ext_ready(ext_ready2), .sen(sen2), .sclk(sclk2), .sdata(sdata2),
    .busy(busy2), .done(done2), .cur_idx(cur_idx2)
  );

  typedef struct {
    logic       do_next;
    logic       do_rep;
    logic       do_ext;
    logic [7:0] ext_word;
    logic [7:0] exp_word;
    int         exp_idx;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Follows one transfer from its ARM cycle until busy drops, acting as the serial receiver.
  task automatic capture(input int which, output logic [7:0] word, output int busy_n,
                         output int done_n, output int done_last, output int phase_bad,
                         output int sen_at, output int sclk_at);
    int   div;
    int   hi_run, lo_run;
    logic prev_sclk, seen_high;
    logic s_sen, s_sclk, s_sdata, s_busy, s_done;
    div = (which != 0) ? 3 : 1;
    word = 8'h00; busy_n = 0; done_n = 0; done_last = 0; phase_bad = 0;
    sen_at = -1; sclk_at = -1; hi_run = 0; lo_run = 0; prev_sclk = 1'b0; seen_high = 1'b0;
    for (int c = 0; c < 300; c++) begin
      s_sen   = (which != 0) ? sen2   : sen;
      s_sclk  = (which != 0) ? sclk2  : sclk;
      s_sdata = (which != 0) ? sdata2 : sdata;
      s_busy  = (which != 0) ? busy2  : busy;
      s_done  = (which != 0) ? done2  : done;
      if (!s_busy) break;
      if (s_done) done_n++;
      done_last = int'(s_done);
      if (s_sen && sen_at < 0) sen_at = busy_n;
      if (s_sclk && sclk_at < 0) sclk_at = busy_n;
      if (s_sclk && !prev_sclk)
        word = (which != 0) ? {word[6:0], s_sdata} : {s_sdata, word[7:1]};
      if (s_sclk) begin
        seen_high = 1'b1;
        hi_run++;
        if (lo_run > 0 && lo_run != div) phase_bad++;
        lo_run = 0;
      end else begin
        if (hi_run > 0 && hi_run != div) phase_bad++;
        hi_run = 0;
        if (s_sen && seen_high) lo_run++;
      end
      prev_sclk = s_sclk;
      busy_n++;
      tick();
    end
    if (lo_run != div) phase_bad++;
  endtask

  task automatic apply(input string name, input int which, input logic dn, input logic dr,
                       input logic de, input logic [7:0] w, input logic [7:0] exp_word,
                       input int exp_idx, input int exp_busy);
    logic [7:0] word;
    int busy_n, done_n, done_last, phase_bad, sen_at, sclk_at;
    if (which != 0) begin
      next_req2 = dn; repeat_req2 = dr;
    end else begin
      next_req = dn; repeat_req = dr; ext_valid = de; ext_cfg = w;
    end
    tick();
    next_req = 1'b0; repeat_req = 1'b0; ext_valid = 1'b0;
    next_req2 = 1'b0; repeat_req2 = 1'b0;
    if (de) chk({name, " ext_ready low after accept"}, int'(ext_ready), 0);
    capture(which, word, busy_n, done_n, done_last, phase_bad, sen_at, sclk_at);
    chk({name, " word"}, int'(word), int'(exp_word));
    chk({name, " busy cycles"}, busy_n, exp_busy);
    chk({name, " done pulses"}, done_n, 1);
    chk({name, " done in last busy cycle"}, done_last, 1);
    chk({name, " phase lengths"}, phase_bad, 0);
    chk({name, " sen rise offset"}, sen_at, 1);
    chk({name, " sclk rise offset"}, sclk_at, 2);
    chk({name, " cur_idx"}, int'((which != 0) ? cur_idx2 : cur_idx), exp_idx);
  endtask

  initial begin
    logic [7:0] word;
    int busy_n, done_n, done_last, phase_bad, sen_at, sclk_at;
    int rises, starts, dones, done_seen, busy_seen;
    logic prev;

    //              next  rep   ext   ext_word exp_word idx
    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 2};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hF0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h5A, 8'h5A, 1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 8'hC3, 8'hC3, 1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h3C, 2};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 2};

    tick();
    tick();
    chk("reset sen", int'(sen), 0);
    chk("reset sclk", int'(sclk), 0);
    chk("reset sdata", int'(sdata), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset ext_ready", int'(ext_ready), 0);
    chk("reset cur_idx", int'(cur_idx), 0);
    chk("reset cur_idx2", int'(cur_idx2), 0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle ext_ready", int'(ext_ready), 1);

    foreach (vecs[i])
      apply($sformatf("v%0d", i), 0, vecs[i].do_next, vecs[i].do_rep, vecs[i].do_ext,
            vecs[i].ext_word, vecs[i].exp_word, vecs[i].exp_idx, 19);

    // next edge arriving mid-transfer must be dropped
    ext_valid = 1'b1; ext_cfg = 8'h66;
    tick();
    ext_valid = 1'b0;
    fork
      capture(0, word, busy_n, done_n, done_last, phase_bad, sen_at, sclk_at);
      begin
        #50 next_req = 1'b1;
        #20 next_req = 1'b0;
      end
    join
    chk("drop word", int'(word), 8'h66);
    chk("drop busy cycles", busy_n, 19);
    busy_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy) busy_seen++;
      tick();
    end
    chk("drop no extra transfer", busy_seen, 0);
    chk("drop cur_idx", int'(cur_idx), 2);

    // reset while bit 4 is on the bus
    next_req = 1'b1;
    tick();
    next_req = 1'b0;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 5) break;
      tick();
    end
    chk("midreset reached bit 4", rises, 5);
    reset = 1'b1;
    tick();
    chk("midreset sen", int'(sen), 0);
    chk("midreset sclk", int'(sclk), 0);
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset cur_idx", int'(cur_idx), 0);
    reset = 1'b0;
    done_seen = 0; busy_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("midreset no done", done_seen, 0);
    chk("midreset stays idle", busy_seen, 0);

    // level held high: one transfer only
    next_req = 1'b1;
    starts = 0; dones = 0; prev = busy;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy && !prev) starts++;
      if (done) dones++;
      prev = busy;
    end
    next_req = 1'b0;
    tick();
    chk("hold transfers", starts, 1);
    chk("hold done pulses", dones, 1);
    chk("hold cur_idx", int'(cur_idx), 1);

    apply("msb div3 next", 1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1, 51);
    apply("msb div3 repeat", 1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1, 51);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
